// File: rtl/amba_ahb_pkg.sv
// rtl/amba_ahb_pkg.sv - AHB bus bundle types and SRAM subordinate helpers
// Purpose: shared AHB manager/subordinate bundles, transfer encodings and the
//          SRAM subordinate state type.
// Ports:   none (package).
package amba_ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  typedef logic [1:0] ahb_trans_t;
  localparam ahb_trans_t AHB_TRANS_IDLE   = 2'b00;
  localparam ahb_trans_t AHB_TRANS_BUSY   = 2'b01;
  localparam ahb_trans_t AHB_TRANS_NONSEQ = 2'b10;
  localparam ahb_trans_t AHB_TRANS_SEQ    = 2'b11;

  typedef logic [2:0] ahb_size_t;
  localparam ahb_size_t AHB_SIZE_BYTE  = 3'd0;
  localparam ahb_size_t AHB_SIZE_HWORD = 3'd1;
  localparam ahb_size_t AHB_SIZE_WORD  = 3'd2;
  localparam ahb_size_t AHB_SIZE_DWORD = 3'd3;

  localparam logic AHB_RESP_OKAY  = 1'b0;
  localparam logic AHB_RESP_ERROR = 1'b1;

  // Manager-to-subordinate bundle (89 bits). hready is the bus HREADY input.
  typedef struct packed {
    logic                      hsel;
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    ahb_trans_t                htrans;
    logic                      hwrite;
    ahb_size_t                 hsize;
    logic [2:0]                hburst;
    logic [6:0]                hprot;
    logic                      hmastlock;
    logic [AHB_DATA_WIDTH-1:0] hwdata;
    logic                      hready;
    logic                      hnonsec;
    logic                      hexcl;
    logic [3:0]                hmaster;
  } s_ahb_mosi_t;

  // Subordinate response bundle (35 bits). hready is HREADYOUT.
  typedef struct packed {
    logic [AHB_DATA_WIDTH-1:0] hrdata;
    logic                      hready;
    logic                      hresp;
    logic                      hexokay;
  } s_ahb_miso_t;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} ahb_sram_st_t;

  // Number of bytes moved by a transfer of the given hsize.
  function automatic logic [7:0] ahb_size_bytes(input ahb_size_t size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// rtl/ahb_sram_bytemem.sv - word-organised flop memory with byte write enables
// Purpose: storage behind the AHB SRAM subordinate. Synchronous write,
//          combinational read, contents are never reset.
// Ports:   clk   - clock
//          we    - per-byte write enable for the addressed word
//          addr  - word address (shared by read and write)
//          wdata - write data, byte lanes little-endian
//          rdata - combinational read of the addressed word
module ahb_sram_bytemem #(
  parameter int WORDS = 1024,
  parameter int DW    = 32,
  parameter int WA    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic [WA-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB subordinate backed by a local flop SRAM
// Purpose: pipelined AHB subordinate with programmable wait states and the
//          two-cycle ERROR response for out-of-range, misaligned or oversized
//          transfers.
// Ports:   hclk     - clock, rising edge
//          hreset   - synchronous active-high reset
//          ahb_mosi - manager bundle; .hready is the bus HREADY input
//          ahb_miso - response bundle; .hready is HREADYOUT
module ahb_sram_slave
  import amba_ahb_pkg::*;
#(
  parameter int          MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  s_ahb_mosi_t ahb_mosi,
  output s_ahb_miso_t ahb_miso
);

  localparam int NB    = AHB_DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / NB;
  localparam int WA    = (WORDS > 1) ? $clog2(WORDS) : 1;

  ahb_sram_st_t   state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  offset_q, offset_d;
  ahb_size_t      size_q, size_d;
  logic           write_q, write_d;
  // An accepted OKAY transfer owns the current/pending data phase.
  logic           dphase_q, dphase_d;

  logic [31:0]    rel;
  logic [7:0]     req_bytes;
  logic           sample;
  logic           addr_err;
  logic           data_done;
  logic [NB-1:0]  be;
  logic [NB-1:0]  mem_we;
  logic [WA-1:0]  word_addr;
  logic [AHB_DATA_WIDTH-1:0] mem_rdata;
  int             lo;
  int             nbytes;

  assign rel       = ahb_mosi.haddr - BASE_ADDR;
  assign req_bytes = ahb_size_bytes(ahb_mosi.hsize);

  // Only IDLE and ERR2 drive HREADYOUT high, so only they may accept a new address.
  assign sample = ahb_mosi.hsel && ahb_mosi.hready &&
                  (ahb_mosi.htrans == AHB_TRANS_NONSEQ || ahb_mosi.htrans == AHB_TRANS_SEQ) &&
                  (state_q == IDLE || state_q == ERR2);

  // Addresses below BASE_ADDR wrap to large values and fail the range test too.
  assign addr_err = (rel >= 32'(MEM_BYTES)) ||
                    ((ahb_mosi.haddr & (32'(req_bytes) - 32'd1)) != 32'd0) ||
                    (req_bytes > 8'(NB));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    size_d   = size_q;
    write_d  = write_q;
    dphase_d = dphase_q;
    case (state_q)
      IDLE, ERR2: begin
        state_d  = IDLE;
        dphase_d = 1'b0;
        if (sample) begin
          offset_d = rel[AW-1:0];
          size_d   = ahb_mosi.hsize;
          write_d  = ahb_mosi.hwrite;
          if (addr_err) begin
            state_d = ERR1;
          end else begin
            dphase_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      offset_q <= '0;
      size_q   <= AHB_SIZE_BYTE;
      write_q  <= 1'b0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      size_q   <= size_d;
      write_q  <= write_d;
      dphase_q <= dphase_d;
    end
  end

  // Byte lanes offset[LB-1:0] .. +2^hsize-1 of the addressed word.
  always_comb begin
    be     = '0;
    lo     = int'(offset_q[LB-1:0]);
    nbytes = int'(ahb_size_bytes(size_q));
    for (int b = 0; b < NB; b++) begin
      be[b] = (b >= lo) && (b < lo + nbytes);
    end
  end

  assign word_addr = WA'(offset_q >> LB);
  // The data phase finishes in the IDLE cycle that follows an accepted transfer.
  assign data_done = dphase_q && (state_q == IDLE);
  // Gating with hreset keeps a reset in the completing cycle from committing.
  assign mem_we    = (data_done && write_q && !hreset) ? be : '0;

  ahb_sram_bytemem #(
    .WORDS (WORDS),
    .DW    (AHB_DATA_WIDTH),
    .WA    (WA)
  ) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .addr  (word_addr),
    .wdata (ahb_mosi.hwdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    ahb_miso         = '0;
    ahb_miso.hready  = !(state_q == WAIT || state_q == ERR1);
    ahb_miso.hresp   = (state_q == ERR1 || state_q == ERR2) ? AHB_RESP_ERROR : AHB_RESP_OKAY;
    ahb_miso.hexokay = 1'b0;
    ahb_miso.hrdata  = (data_done && !write_q) ? mem_rdata : '0;
  end

  logic unused_bits;
  assign unused_bits = ^{ahb_mosi.hburst, ahb_mosi.hprot, ahb_mosi.hmastlock,
                         ahb_mosi.hnonsec, ahb_mosi.hexcl, ahb_mosi.hmaster};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
  import amba_ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  s_ahb_mosi_t drv0, drv2, mosi0, mosi2;
  s_ahb_miso_t miso0, miso2;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 hclk = ~hclk;

  // Single-subordinate bus: HREADY is the subordinate's own HREADYOUT.
  always_comb begin
    mosi0 = drv0;
    mosi0.hready = miso0.hready;
  end
  always_comb begin
    mosi2 = drv2;
    mosi2.hready = miso2.hready;
  end

  ahb_sram_slave #(.MEM_BYTES(4096), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .hclk     (hclk),
    .hreset   (hreset),
    .ahb_mosi (mosi0),
    .ahb_miso (miso0)
  );

  ahb_sram_slave #(.MEM_BYTES(4096), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut2 (
    .hclk     (hclk),
    .hreset   (hreset),
    .ahb_mosi (mosi2),
    .ahb_miso (miso2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Present an address phase and the write data for the data phase in progress.
  task automatic bus0(input ahb_trans_t tr, input logic wr, input ahb_size_t sz,
                      input logic [31:0] addr, input logic [31:0] wd);
    drv0.hsel   = 1'b1;
    drv0.htrans = tr;
    drv0.hwrite = wr;
    drv0.hsize  = sz;
    drv0.haddr  = addr;
    drv0.hwdata = wd;
    tick();
  endtask

  task automatic bus2(input ahb_trans_t tr, input logic wr, input ahb_size_t sz,
                      input logic [31:0] addr, input logic [31:0] wd);
    drv2.hsel   = 1'b1;
    drv2.htrans = tr;
    drv2.hwrite = wr;
    drv2.hsize  = sz;
    drv2.haddr  = addr;
    drv2.hwdata = wd;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ahb_trans_t  rd_tr   [5] = '{AHB_TRANS_NONSEQ, AHB_TRANS_SEQ, AHB_TRANS_BUSY, AHB_TRANS_SEQ, AHB_TRANS_SEQ};
    logic [31:0] rd_addr [5] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h4C};
    logic [31:0] rd_exp  [5] = '{32'd1, 32'd2, 32'd0, 32'd3, 32'd4};
    int k, done, cyc;

    drv0 = '0;
    drv2 = '0;
    hreset = 1'b1;
    repeat (3) tick();
    check_eq("rst_hready0", miso0.hready, 1);
    check_eq("rst_hresp0", miso0.hresp, 0);
    check_eq("rst_hrdata0", miso0.hrdata, 0);
    check_eq("rst_hexokay0", miso0.hexokay, 0);
    check_eq("rst_hready2", miso2.hready, 1);
    hreset = 1'b0;
    tick();

    // Write word then read it back on the next cycle.
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h10, 32'h0);
    check_eq("wr_hready", miso0.hready, 1);
    check_eq("wr_hresp", miso0.hresp, 0);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h10, 32'hDEADBEEF);
    check_eq("rd_hready", miso0.hready, 1);
    check_eq("rd_hresp", miso0.hresp, 0);
    check_eq("rd_data", miso0.hrdata, 32'hDEADBEEF);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    check_eq("idle_hready", miso0.hready, 1);
    check_eq("idle_hrdata", miso0.hrdata, 0);

    // Byte lane merge.
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h20, 32'h0);
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_BYTE, 32'h21, 32'h11223344);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h20, 32'h0000AA00);
    check_eq("byte_merge", miso0.hrdata, 32'h1122AA44);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);

    // Seed word 0, then out-of-range read.
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h0, 32'h0);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'hCAFEF00D);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h1000, 32'h0);
    check_eq("oor_e1_hready", miso0.hready, 0);
    check_eq("oor_e1_hresp", miso0.hresp, 1);
    check_eq("oor_e1_hrdata", miso0.hrdata, 0);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    check_eq("oor_e2_hready", miso0.hready, 1);
    check_eq("oor_e2_hresp", miso0.hresp, 1);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    check_eq("oor_after_hresp", miso0.hresp, 0);

    // Misaligned halfword write must not touch memory.
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_HWORD, 32'h3, 32'h0);
    check_eq("mis_e1_hready", miso0.hready, 0);
    check_eq("mis_e1_hresp", miso0.hresp, 1);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'hFFFFFFFF);
    check_eq("mis_e2_hready", miso0.hready, 1);
    check_eq("mis_e2_hresp", miso0.hresp, 1);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'hFFFFFFFF);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    check_eq("mis_mem_kept", miso0.hrdata, 32'hCAFEF00D);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);

    // Oversized transfer errors; a new address during ERR2 is accepted.
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_DWORD, 32'h8, 32'h0);
    check_eq("big_e1_hresp", miso0.hresp, 1);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    check_eq("big_e2_hresp", miso0.hresp, 1);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h10, 32'h0);
    check_eq("err2_pipe_hresp", miso0.hresp, 0);
    check_eq("err2_pipe_data", miso0.hrdata, 32'hDEADBEEF);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);

    // Last word of the window.
    bus0(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'hFFC, 32'h0);
    bus0(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'hFFC, 32'h13579BDF);
    check_eq("top_word_hresp", miso0.hresp, 0);
    check_eq("top_word_data", miso0.hrdata, 32'h13579BDF);
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);

    // INCR4 write burst of 1..4 at 0x40.
    for (int i = 0; i < 5; i++) begin
      bus0((i == 0) ? AHB_TRANS_NONSEQ : ((i < 4) ? AHB_TRANS_SEQ : AHB_TRANS_IDLE),
           1'b1, AHB_SIZE_WORD, 32'h40 + 32'(4 * i), 32'(i));
      if (i < 4) check_eq($sformatf("bw_hready%0d", i), miso0.hready, 1);
    end

    // Read burst with a BUSY beat inserted.
    for (int i = 0; i < 5; i++) begin
      bus0(rd_tr[i], 1'b0, AHB_SIZE_WORD, rd_addr[i], 32'h0);
      check_eq($sformatf("br_hready%0d", i), miso0.hready, 1);
      check_eq($sformatf("br_hresp%0d", i), miso0.hresp, 0);
      check_eq($sformatf("br_data%0d", i), miso0.hrdata, rd_exp[i]);
    end
    bus0(AHB_TRANS_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
    drv0.hsel = 1'b0;

    // WAIT_STATES=2: seed 0x30 with a write.
    bus2(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h30, 32'h0);
    drv2.htrans = AHB_TRANS_IDLE;
    drv2.hwdata = 32'h55555555;
    check_eq("w2_c1_hready", miso2.hready, 0);
    tick();
    tick();
    check_eq("w2_c3_hready", miso2.hready, 1);
    tick();

    // Single read: two wait cycles then data.
    bus2(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h30, 32'h0);
    drv2.htrans = AHB_TRANS_IDLE;
    check_eq("r2_c1_hready", miso2.hready, 0);
    check_eq("r2_c1_hresp", miso2.hresp, 0);
    tick();
    check_eq("r2_c2_hready", miso2.hready, 0);
    tick();
    check_eq("r2_c3_hready", miso2.hready, 1);
    check_eq("r2_c3_data", miso2.hrdata, 32'h55555555);
    tick();

    // Reset during the wait states of a write aborts it.
    bus2(AHB_TRANS_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h30, 32'h0);
    drv2.htrans = AHB_TRANS_IDLE;
    drv2.hwdata = 32'h0BADF00D;
    hreset = 1'b1;
    tick();
    check_eq("rstw_hready", miso2.hready, 1);
    check_eq("rstw_hresp", miso2.hresp, 0);
    hreset = 1'b0;
    tick();
    check_eq("rstw_idle_hready", miso2.hready, 1);
    bus2(AHB_TRANS_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h30, 32'h0);
    drv2.htrans = AHB_TRANS_IDLE;
    tick();
    tick();
    check_eq("rstw_mem_kept", miso2.hrdata, 32'h55555555);
    tick();

    // INCR4 read burst with two wait states per beat.
    drv2.hsel   = 1'b1;
    drv2.htrans = AHB_TRANS_NONSEQ;
    drv2.hwrite = 1'b0;
    drv2.hsize  = AHB_SIZE_WORD;
    drv2.haddr  = 32'h30;
    k = 1;
    done = 0;
    cyc = 0;
    while (done < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (miso2.hready) begin
        done++;
        if (k < 4) begin
          drv2.htrans = AHB_TRANS_SEQ;
          drv2.haddr  = 32'h30 + 32'(4 * k);
          k++;
        end else begin
          drv2.htrans = AHB_TRANS_IDLE;
        end
      end
    end
    check_eq("burst2_beats", 32'(done), 4);
    check_eq("burst2_cycles", 32'(cyc), 12);
    drv2.hsel = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
